// File: rtl/beam_i2s_tx_if.sv
// Sample-pair handshake plus I2S serial outputs of the beamformer transmit stage.
// master = producer/observer side, slave = beam_i2s_tx.
interface beam_i2s_tx_if #(
    parameter int NUMBER_OF_BITS = 8
);
    logic [NUMBER_OF_BITS-1:0] sample_a;
    logic [NUMBER_OF_BITS-1:0] sample_b;
    logic                      sample_valid;
    logic                      sample_ready;
    logic                      sd;
    logic                      ws;
    logic                      frame_start;
    logic                      underrun;
    logic [7:0]                underrun_cnt;

    modport master (
        output sample_a, sample_b, sample_valid,
        input  sample_ready, sd, ws, frame_start, underrun, underrun_cnt
    );

    modport slave (
        input  sample_a, sample_b, sample_valid,
        output sample_ready, sd, ws, frame_start, underrun, underrun_cnt
    );
endinterface

// File: rtl/beam_i2s_tx.sv
// Sum/difference beam former feeding a Philips-I2S stereo transmitter
// (sum in the left slot, difference in the right) behind a one-deep holding register.
module beam_i2s_tx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16
) (
    input  logic          clk,
    input  logic          reset,
    beam_i2s_tx_if.slave  bus
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST       = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_START = CW'(SLOT_BITS);

    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_nxt;
    logic [NUMBER_OF_BITS-1:0] hold_a;
    logic [NUMBER_OF_BITS-1:0] hold_b;
    logic                      holding_full;
    logic                      holding_full_nxt;
    logic [NUMBER_OF_BITS-1:0] word_l;
    logic [NUMBER_OF_BITS-1:0] word_r;
    logic [NUMBER_OF_BITS-1:0] rev_l;
    logic [NUMBER_OF_BITS-1:0] rev_r;
    logic [FRAME_BITS-1:0]     frame_vec;
    logic [NUMBER_OF_BITS:0]   sum_full;
    logic [NUMBER_OF_BITS:0]   dif_full;
    logic                      load;
    logic                      accept;
    logic                      sd_nxt;
    logic                      ws_nxt;
    logic                      underrun_nxt;
    logic                      sd_q;
    logic                      ws_q;
    logic                      frame_start_q;
    logic                      underrun_q;
    logic [7:0]                underrun_cnt_q;

    always_comb begin
        load     = (cnt == LAST);
        cnt_nxt  = load ? '0 : cnt + 1'b1;
        accept   = bus.sample_valid && !holding_full;
        sum_full = {hold_a[NUMBER_OF_BITS-1], hold_a} + {hold_b[NUMBER_OF_BITS-1], hold_b};
        dif_full = {hold_a[NUMBER_OF_BITS-1], hold_a} - {hold_b[NUMBER_OF_BITS-1], hold_b};
        // A load with a full holding register drains it; an empty one may capture at that edge.
        holding_full_nxt = load ? accept : (holding_full || accept);
        // Underrun is flagged during the last period, based on what the load edge will find.
        underrun_nxt = (cnt_nxt == LAST) && !holding_full_nxt;
        ws_nxt   = (cnt_nxt >= SLOT_START);
        rev_l    = {<<{word_l}};
        rev_r    = {<<{word_r}};
        // frame_vec[k] is the bit on sd in period k; words go out MSB first after a 1-bit delay.
        frame_vec = (FRAME_BITS'(rev_l) << 1) | (FRAME_BITS'(rev_r) << (SLOT_BITS + 1));
        sd_nxt   = frame_vec[cnt_nxt];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            sd_q           <= 1'b0;
            ws_q           <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            holding_full   <= 1'b0;
            hold_a         <= '0;
            hold_b         <= '0;
            word_l         <= '0;
            word_r         <= '0;
        end else begin
            cnt           <= cnt_nxt;
            sd_q          <= sd_nxt;
            ws_q          <= ws_nxt;
            frame_start_q <= (cnt_nxt == '0);
            underrun_q    <= underrun_nxt;
            if (underrun_nxt && (underrun_cnt_q != '1))
                underrun_cnt_q <= underrun_cnt_q + 8'd1;
            holding_full <= holding_full_nxt;
            if (accept) begin
                hold_a <= bus.sample_a;
                hold_b <= bus.sample_b;
            end
            if (load) begin
                if (holding_full) begin
                    word_l <= sum_full[NUMBER_OF_BITS:1];
                    word_r <= dif_full[NUMBER_OF_BITS:1];
                end else begin
                    word_l <= '0;
                    word_r <= '0;
                end
            end
        end
    end

    assign bus.sample_ready = !holding_full;
    assign bus.sd           = sd_q;
    assign bus.ws           = ws_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = underrun_cnt_q;
endmodule
